// File: rtl/ccd_fifo_pkg.sv
// Shared constants and helpers for the convolution FIFO front ends.
// Used by ccd_rr_arbiter and ccd_fifo_rd_streamer.
package ccd_fifo_pkg;

    localparam int CCD_DEF_DATA_WIDTH = 16;
    localparam int CCD_CNT_WIDTH      = 32;

    // Channel id width; never narrower than one bit.
    function automatic int ch_id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ccd_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or
// above the pointer (with wrap); the pointer moves past the winner.
// Ports: clk, rst (sync, active-high), req[NUM_CH] in;
//        gnt[NUM_CH] one-hot out, gnt_id, gnt_vld out.
module ccd_rr_arbiter
    import ccd_fifo_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int IDW   = ch_id_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDW-1:0]    gnt_id,
    output logic              gnt_vld
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_id == IDW'(NUM_CH - 1)) ? '0 : gnt_id + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ccd_fifo_rd_streamer.sv
// Multi-channel FIFO read front end: credit-gated round-robin reads,
// fixed-latency capture, and a FIFO-ordered output buffer.
// Ports: rd_clk, rd_rst (sync, active-high), enable, ch_empty,
//        ch_rd_en, ch_rd_data, m_valid/m_ready/m_data/m_ch, busy.
// Optional: `define CCD_RD_CNT_EN adds rd_cnt (32-bit per channel).
module ccd_fifo_rd_streamer
    import ccd_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CCD_DEF_DATA_WIDTH,
    parameter int NUM_CH     = 4,
    parameter int RD_LATENCY = 1,
    parameter int OBUF_DEPTH = 4,
    localparam int IDW       = ch_id_width(NUM_CH)
) (
    input  logic                         rd_clk,
    input  logic                         rd_rst,
    input  logic                         enable,
    input  logic [NUM_CH-1:0]            ch_empty,
    output logic [NUM_CH-1:0]            ch_rd_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rd_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [IDW-1:0]               m_ch,
    output logic                         busy
`ifdef CCD_RD_CNT_EN
    ,
    output logic [NUM_CH*CCD_CNT_WIDTH-1:0] rd_cnt
`endif
);

    localparam int PW = $clog2(OBUF_DEPTH);
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam int LW = $clog2(RD_LATENCY + 1);

    logic [NUM_CH-1:0]     req;
    logic [IDW-1:0]        gnt_id;
    logic                  gnt_vld;
    logic                  allow;
    logic [LW-1:0]         infl;

    logic [RD_LATENCY-1:0] pv_q, pv_d;
    logic [IDW-1:0]        pid_q [RD_LATENCY];
    logic [IDW-1:0]        pid_d [RD_LATENCY];

    logic [DATA_WIDTH-1:0] md_q [OBUF_DEPTH];
    logic [DATA_WIDTH-1:0] md_d [OBUF_DEPTH];
    logic [IDW-1:0]        mc_q [OBUF_DEPTH];
    logic [IDW-1:0]        mc_d [OBUF_DEPTH];
    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]         occ_q, occ_d;

    logic                  push, pop;
    logic [IDW-1:0]        cap_id;
    logic [DATA_WIDTH-1:0] cap_data;

    always_comb begin
        infl = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            infl = infl + LW'(pv_q[i]);
        end
    end

    // Credit counts words already in flight plus buffered ones, so a
    // capture can never land on a full buffer.
    assign allow = !rd_rst && enable &&
                   (int'(infl) + int'(occ_q) < OBUF_DEPTH);
    assign req   = ~ch_empty & {NUM_CH{allow}};

    ccd_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (rd_clk),
        .rst     (rd_rst),
        .req     (req),
        .gnt     (ch_rd_en),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        pv_d     = '0;
        pid_d    = pid_q;
        pv_d[0]  = gnt_vld;
        pid_d[0] = gnt_id;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pv_d[i]  = pv_q[i-1];
            pid_d[i] = pid_q[i-1];
        end
    end

    assign push     = pv_q[RD_LATENCY-1];
    assign cap_id   = pid_q[RD_LATENCY-1];
    assign cap_data = ch_rd_data[int'(cap_id)*DATA_WIDTH +: DATA_WIDTH];

    assign m_valid = (occ_q != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? md_q[rp_q] : '0;
    assign m_ch    = m_valid ? mc_q[rp_q] : '0;
    assign busy    = (infl != '0) || (occ_q != '0);

    always_comb begin
        md_d  = md_q;
        mc_d  = mc_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        occ_d = occ_q + CW'(push) - CW'(pop);
        if (push) begin
            md_d[wp_q] = cap_data;
            mc_d[wp_q] = cap_id;
            wp_d       = wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = rp_q + PW'(1);
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            pv_q  <= '0;
            pid_q <= '{default: '0};
            wp_q  <= '0;
            rp_q  <= '0;
            occ_q <= '0;
        end else begin
            pv_q  <= pv_d;
            pid_q <= pid_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            occ_q <= occ_d;
        end
    end

    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge rd_clk) begin
        md_q <= md_d;
        mc_q <= mc_d;
    end

`ifdef CCD_RD_CNT_EN
    logic [CCD_CNT_WIDTH-1:0] cnt_q [NUM_CH];
    logic [CCD_CNT_WIDTH-1:0] cnt_d [NUM_CH];

    always_comb begin
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d[m_ch] = cnt_q[m_ch] + CCD_CNT_WIDTH'(1);
        end
    end

    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_cnt[i*CCD_CNT_WIDTH +: CCD_CNT_WIDTH] = cnt_q[i];
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) cnt_q <= '{default: '0};
        else        cnt_q <= cnt_d;
    end
`endif

    obuf_no_overflow: assert property (
        @(posedge rd_clk) disable iff (rd_rst)
        !(push && !pop && occ_q == CW'(OBUF_DEPTH))
    );

endmodule

// File: tb/tb_ccd_fifo_rd_streamer.sv
// Directed bench for ccd_fifo_rd_streamer with a latency-1 FIFO model.
// Words carry 0x1000 | ch<<8 | per-channel sequence number.
module tb_ccd_fifo_rd_streamer;

    localparam int DW = 16;
    localparam int NC = 4;

    logic            rd_clk;
    logic            rd_rst;
    logic            enable;
    logic [NC-1:0]   ch_empty;
    logic [NC-1:0]   ch_rd_en;
    logic [NC*DW-1:0] ch_rd_data;
    logic            m_valid;
    logic            m_ready;
    logic [DW-1:0]   m_data;
    logic [1:0]      m_ch;
    logic            busy;
`ifdef CCD_RD_CNT_EN
    logic [NC*32-1:0] rd_cnt;
`endif

    ccd_fifo_rd_streamer #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NC),
        .RD_LATENCY (1),
        .OBUF_DEPTH (4)
    ) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .enable     (enable),
        .ch_empty   (ch_empty),
        .ch_rd_en   (ch_rd_en),
        .ch_rd_data (ch_rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_ch       (m_ch),
        .busy       (busy)
`ifdef CCD_RD_CNT_EN
        ,
        .rd_cnt     (rd_cnt)
`endif
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic [7:0] seq [NC];
    always @(posedge rd_clk) begin
        if (rd_rst) begin
            for (int i = 0; i < NC; i++) seq[i] <= 8'd0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (ch_rd_en[i]) begin
                    ch_rd_data[i*DW +: DW] <= 16'h1000 + 16'(i*256) + 16'(seq[i]);
                    seq[i] <= seq[i] + 8'd1;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int nwords = 0;
    logic [7:0] exp_seq [NC];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic check_word();
        chk("word", 32'(m_data),
            32'(16'h1000 + 16'(int'(m_ch)*256) + 16'(exp_seq[m_ch])));
        exp_seq[m_ch] = exp_seq[m_ch] + 8'd1;
        nwords++;
    endtask

    task automatic drain(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (!busy) break;
            if (m_valid && m_ready) check_word();
            tick();
        end
        chk("drain_done", 32'(busy), 32'd0);
    endtask

    task automatic reset_dut();
        rd_rst   = 1'b1;
        enable   = 1'b0;
        m_ready  = 1'b0;
        ch_empty = '1;
        tick();
        tick();
        rd_rst = 1'b0;
        for (int i = 0; i < NC; i++) exp_seq[i] = 8'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    logic [DW-1:0] hold;
    logic          have;
    logic          resumed;
    int            nreads;

    initial begin
        reset_dut();
        #1;
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rden", 32'(ch_rd_en), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_ch", 32'(m_ch), 0);

        enable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("idle_rden", 32'(ch_rd_en), 0);
            chk("idle_valid", 32'(m_valid), 0);
            chk("idle_busy", 32'(busy), 0);
            tick();
        end

        // single ch2 read: m_valid two cycles after the strobe
        ch_empty = 4'b1011;
        #1;
        chk("lat_rden", 32'(ch_rd_en), 32'b0100);
        tick();
        ch_empty = 4'b1111;
        #1;
        chk("lat_v_t1", 32'(m_valid), 0);
        chk("lat_busy", 32'(busy), 1);
        tick();
        chk("lat_v_t2", 32'(m_valid), 1);
        chk("lat_ch", 32'(m_ch), 2);
        check_word();
        m_ready = 1'b1;
        tick();
        chk("lat_pop_v", 32'(m_valid), 0);
        chk("lat_pop_busy", 32'(busy), 0);

        // round robin, full throughput
        reset_dut();
        enable   = 1'b1;
        m_ready  = 1'b1;
        ch_empty = 4'b0000;
        tick();
        tick();
        for (int k = 0; k < 12; k++) begin
            chk("rr_valid", 32'(m_valid), 1);
            chk("rr_ch", 32'(m_ch), 32'(k % 4));
            check_word();
            tick();
        end
        ch_empty = '1;
        drain(20);

        // backpressure: credit stops issue at four words
        ch_empty = 4'b0000;
        m_ready  = 1'b0;
        nreads   = 0;
        have     = 1'b0;
        hold     = '0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (ch_rd_en != '0) nreads++;
            chk("bp_onehot", 32'($onehot0(ch_rd_en)), 1);
            if (m_valid) begin
                if (!have) begin
                    hold = m_data;
                    have = 1'b1;
                end else begin
                    chk("bp_hold", 32'(m_data), 32'(hold));
                end
            end
            tick();
        end
        chk("bp_reads", 32'(nreads), 4);
        chk("bp_full_v", 32'(m_valid), 1);
        m_ready = 1'b1;
        resumed = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (ch_rd_en != '0) resumed = 1'b1;
            if (m_valid) check_word();
            tick();
        end
        chk("bp_resume", 32'(resumed), 1);
        ch_empty = '1;
        drain(20);

        // enable drop with one read in flight
        ch_empty = 4'b1110;
        #1;
        chk("en_issue", 32'(ch_rd_en), 32'b0001);
        tick();
        enable = 1'b0;
        #1;
        chk("en_stop1", 32'(ch_rd_en), 0);
        chk("en_busy1", 32'(busy), 1);
        tick();
        chk("en_stop2", 32'(ch_rd_en), 0);
        chk("en_valid", 32'(m_valid), 1);
        chk("en_ch", 32'(m_ch), 0);
        check_word();
        tick();
        chk("en_busy0", 32'(busy), 0);
        chk("en_valid0", 32'(m_valid), 0);
        ch_empty = '1;

        // reset with three buffered words
        enable   = 1'b1;
        m_ready  = 1'b0;
        ch_empty = 4'b1101;
        tick();
        tick();
        tick();
        ch_empty = 4'b1111;
        tick();
        chk("mr_valid", 32'(m_valid), 1);
        chk("mr_busy", 32'(busy), 1);
        rd_rst = 1'b1;
        tick();
        chk("mr_rst_v", 32'(m_valid), 0);
        chk("mr_rst_busy", 32'(busy), 0);
        chk("mr_rst_data", 32'(m_data), 0);
`ifdef CCD_RD_CNT_EN
        chk("mr_cnt0", rd_cnt[31:0], 0);
        chk("mr_cnt1", rd_cnt[63:32], 0);
        chk("mr_cnt2", rd_cnt[95:64], 0);
        chk("mr_cnt3", rd_cnt[127:96], 0);
`endif
        rd_rst = 1'b0;
        for (int i = 0; i < NC; i++) exp_seq[i] = 8'd0;
        nwords   = 0;
        m_ready  = 1'b1;
        ch_empty = 4'b1101;
        for (int c = 0; c < 5; c++) begin
            if (m_valid) check_word();
            tick();
        end
        ch_empty = 4'b1111;
        drain(20);
        chk("mr_words", 32'(nwords), 5);
        chk("mr_seq1", 32'(exp_seq[1]), 5);
`ifdef CCD_RD_CNT_EN
        chk("cnt1", rd_cnt[63:32], 5);
        chk("cnt0", rd_cnt[31:0], 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccd_fifo_rd_streamer.md
Name: ccd_fifo_rd_streamer

Overview:
Multi-channel FIFO read front end for the convolution datapath. It round-robin arbitrates across NUM_CH FIFO read ports and issues read enables only when there is credit. It captures the FIFO read data after a fixed read latency and presents it as a valid/ready stream tagged with the source channel. An output buffer absorbs backpressure, so no word is dropped or duplicated.

Parameters:
- DATA_WIDTH, 16, width of each FIFO word and of m_data.
- NUM_CH, 4, number of FIFO channels (2..16).
- RD_LATENCY, 1, cycles from ch_rd_en to valid ch_rd_data (1 or 2).
- OBUF_DEPTH, 4, output buffer entries (power of 2, at least RD_LATENCY+1).

Ports:
- rd_clk, in, 1, sole clock; all logic on its rising edge.
- rd_rst, in, 1, synchronous, active-high reset.
- enable, in, 1, permits new reads; low stops issue, in-flight words still drain.
- ch_empty, in, NUM_CH, per-channel FIFO empty flag.
- ch_rd_en, out, NUM_CH, one-hot or zero read strobe.
- ch_rd_data, in, NUM_CH*DATA_WIDTH, flattened; channel i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_valid, out, 1, stream word valid.
- m_ready, in, 1, downstream accept.
- m_data, out, DATA_WIDTH, stream word.
- m_ch, out, max(1,$clog2(NUM_CH)), source channel of m_data.
- busy, out, 1, high while words are in flight or buffered.

Behaviour:
- Reset: ch_rd_en=0, m_valid=0, m_data=0, m_ch=0, busy=0. Arbiter pointer=0. In-flight pipeline cleared. Buffer emptied. Reset mid-transfer discards all in-flight and buffered words.
- Credit: issue is allowed when enable=1 and inflight+occupancy < OBUF_DEPTH.
  - inflight is the count of reads issued but not yet captured, at most RD_LATENCY.
- Grant: in an allowed cycle, grant the first channel i with ch_empty[i]=0, searching from the pointer upward with wrap. Assert ch_rd_en[i] combinationally in that same cycle.
  - After a grant, pointer = (i+1) mod NUM_CH.
  - With no grant, the pointer holds.
  - At most one ch_rd_en bit is high per cycle.
- Capture: a grant at cycle t uses a shift pipeline of {valid, ch id} of length RD_LATENCY. At cycle t+RD_LATENCY, ch_rd_data[id] is written into the buffer.
  - m_valid can first rise at t+RD_LATENCY+1, so minimum latency from ch_rd_en to m_valid is RD_LATENCY+1 cycles.
- Output: FIFO-ordered buffer.
  - m_valid = buffer non-empty. m_data and m_ch come from the head entry and must hold stable while m_valid=1 and m_ready=0.
  - A pop occurs on m_valid & m_ready.
  - A simultaneous push and pop leaves occupancy unchanged.
  - The credit rule guarantees a push never meets a full buffer. Overflow is an assertion failure.
  - Full throughput: with m_ready held high and at least one non-empty channel, one word per cycle in steady state.
- ch_empty is sampled only in the issue cycle. A channel going empty while its read is in flight does not affect that read.
- enable falling stops issue in the same cycle. The pipeline and buffer drain normally.
- busy = (inflight != 0) | (occupancy != 0).
- No FSM states beyond the implicit ones: issue allowed vs blocked, and buffer empty/partial/full. The state is held in counters.

Optional Feature:
- Macro CCD_RD_CNT_EN.
- Defined: adds output rd_cnt, NUM_CH*32 bits.
  - One 32-bit counter per channel, incremented on each m_valid & m_ready for that m_ch.
  - Cleared on rd_rst; wraps at 2^32-1 to 0.
- Undefined: no port and no counters; behaviour otherwise identical.

Decomposition:
- Package ccd_fifo_pkg holds:
  - constants CCD_DEF_DATA_WIDTH=16 and CCD_CNT_WIDTH=32;
  - function ch_id_width(n), returning max(1,$clog2(n)).
- Sub-module ccd_rr_arbiter(NUM_CH) implements the request vector in, one-hot grant out, and the pointer register with update on grant. It is reused by the write-side block.
- Buffer and latency pipeline stay inline.

Test Plan:
- Reset then idle: all ch_empty=1, enable=1 for 20 cycles -> ch_rd_en=0, m_valid=0, busy=0 throughout.
- Round-robin fairness: NUM_CH=4, all channels non-empty with data 0x1000+i, m_ready=1 -> m_ch sequence 0,1,2,3,0,..., one word per cycle after a 2-cycle startup.
- Latency: only ch2 non-empty in one cycle, RD_LATENCY=1 -> ch_rd_en[2] at t, m_valid at t+2 with m_ch=2.
- Backpressure: all channels full, m_ready=0 for 10 cycles -> at most OBUF_DEPTH=4 reads issued. m_data holds stable. After release, 4 words drain in order with no loss or duplicates, and issue resumes.
- enable drop mid-stream: enable->0 while 1 read is in flight -> no further ch_rd_en; the in-flight word appears on m_valid; busy falls once it is accepted.
- Reset mid-operation, plus CCD_RD_CNT_EN: rd_rst asserted with 3 buffered words -> next cycle m_valid=0 and rd_cnt all 0. After 5 accepted ch1 words, rd_cnt[1]=5.
